// File: rtl/arb_merge_n_sync.sv
// N-channel arbiter-merge: 1-entry slot per input channel, one token forwarded per send.
// Round-robin grant by default; define ARB_FIXED_PRIORITY_EN for lowest-index-first grant.
module arb_merge_n_sync #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned DATA_WIDTH = 5,
   localparam int unsigned SRC_W     = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [N_CH-1:0]            i_drive,
   input  logic [N_CH*DATA_WIDTH-1:0] i_data,
   output logic [N_CH-1:0]            o_free,
   output logic [N_CH-1:0]            o_overflow,
   output logic                       o_driveNext,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic [SRC_W-1:0]           o_src,
   input  logic                       i_freeNext
);

   typedef enum logic {StIdle, StWait} state_e;

   state_e                state_q, state_d;
   logic [N_CH-1:0]       v_q, v_d;
   logic [DATA_WIDTH-1:0] slot_q [N_CH];
   logic [DATA_WIDTH-1:0] slot_d [N_CH];
   logic [N_CH-1:0]       ovf_q, ovf_d;
   logic [N_CH-1:0]       free_q, free_d;
   logic                  dn_q, dn_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SRC_W-1:0]      src_q, src_d;

   logic [SRC_W-1:0]      grant;
   logic                  any_v;
   logic                  send;

   assign any_v = |v_q;
   assign send  = any_v && ((state_q == StIdle) || i_freeNext);

`ifdef ARB_FIXED_PRIORITY_EN
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (!found && v_q[k]) begin
            grant = SRC_W'(k);
            found = 1'b1;
         end
      end
   end
`else
   logic [SRC_W-1:0] ptr_q, ptr_d;
   logic [31:0]      rr_idx;
   logic             found;

   // Search starts at ptr and wraps, so every waiting slot is reached within N_CH sends.
   always_comb begin
      grant  = '0;
      found  = 1'b0;
      rr_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         rr_idx = (32'(ptr_q) + i) % N_CH;
         if (!found && v_q[rr_idx[SRC_W-1:0]]) begin
            grant = rr_idx[SRC_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (send) begin
         ptr_d = (grant == SRC_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_v) state_d = StWait;
         StWait:  if (i_freeNext && !any_v) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      v_d    = v_q;
      slot_d = slot_q;
      ovf_d  = ovf_q | (i_drive & v_q);
      free_d = '0;
      dn_d   = send;
      data_d = data_q;
      src_d  = src_q;
      if (send) begin
         v_d[grant]    = 1'b0;
         free_d[grant] = 1'b1;
         data_d        = slot_q[grant];
         src_d         = grant;
      end
      // Capture only into slots empty before the edge; a slot freed this edge still drops.
      for (int k = 0; k < N_CH; k++) begin
         if (i_drive[k] && !v_q[k]) begin
            v_d[k]    = 1'b1;
            slot_d[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         v_q     <= '0;
         ovf_q   <= '0;
         free_q  <= '0;
         dn_q    <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         ovf_q   <= ovf_d;
         free_q  <= free_d;
         dn_q    <= dn_d;
         data_q  <= data_d;
         src_q   <= src_d;
         for (int k = 0; k < N_CH; k++) begin
            slot_q[k] <= slot_d[k];
         end
      end
   end

   assign o_free      = free_q;
   assign o_overflow  = ovf_q;
   assign o_driveNext = dn_q;
   assign o_data      = data_q;
   assign o_src       = src_q;

endmodule
